mem_port_arbiter: RTL

//  Shares the single memory port between I-cache (read-only line fills) and D-cache (fills + write-backs).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// port owner encoding and the word size used for beat address stepping.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IC,
    OWN_DC
  } owner_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requesters.
// Fixed D-cache priority by default; ARB_ROUND_ROBIN_EN alternates on conflicts.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   ic_req_i,
  input  logic   dc_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e last_owner_i,
`endif
  output owner_e winner_o
);

  // A lone requester always wins; only simultaneous requests consult the policy.
  always_comb begin
    winner_o = OWN_NONE;
    if (ic_req_i && dc_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner_o = (last_owner_i == OWN_DC) ? OWN_IC : OWN_DC;
`else
      winner_o = OWN_DC;
`endif
    end else if (dc_req_i) begin
      winner_o = OWN_DC;
    end else if (ic_req_i) begin
      winner_o = OWN_IC;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache and D-cache, one full line per grant.
// Define ARB_ROUND_ROBIN_EN for alternating arbitration instead of D-cache priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ic_req_valid,
  input  logic [ADDR_W-1:0]        ic_req_addr,
  output logic                     ic_rsp_valid,
  output logic [31:0]              ic_rsp_data,
  output logic                     ic_done,
  input  logic                     dc_req_valid,
  input  logic [ADDR_W-1:0]        dc_req_addr,
  input  logic                     dc_req_wr,
  input  logic [31:0]              dc_wr_data,
  output logic [$clog2(BEATS)-1:0] dc_beat_idx,
  output logic                     dc_rsp_valid,
  output logic [31:0]              dc_rsp_data,
  output logic                     dc_done,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic                     mem_req_valid,
  output logic                     mem_req_wr,
  output logic [31:0]              mem_wr_data,
  input  logic [31:0]              mem_req_data,
  input  logic                     mem_req_ready
);

  localparam int BW = $clog2(BEATS);
  localparam int WB_W = $clog2(WORD_BYTES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BEATS * WORD_BYTES - 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               wr_q, wr_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic               icRspValid_q, dcRspValid_q;
  logic [31:0]        rspData_q;
  owner_e             winner;
  logic               rdAccept;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e lastOwner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastOwner_q <= OWN_IC;
    end else if (state_q == ST_IDLE && winner != OWN_NONE) begin
      lastOwner_q <= winner;
    end
  end
`endif

  mem_arb_pick uPick (
    .ic_req_i     (ic_req_valid),
    .dc_req_i     (dc_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner_i (lastOwner_q),
`endif
    .winner_o     (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      base_q  <= '0;
      wr_q    <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
      beat_q  <= beat_d;
    end
  end

  // Owner, line base and direction are latched only at grant and held to the end of the line.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    wr_d    = wr_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          state_d = ST_BUSY;
          owner_d = winner;
          base_d  = ((winner == OWN_DC) ? dc_req_addr : ic_req_addr) & ~LINE_MASK;
          wr_d    = (winner == OWN_DC) && dc_req_wr;
          beat_d  = '0;
        end
      end
      ST_BUSY: begin
        if (mem_req_ready) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        wr_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wr    = 1'b0;
    mem_wr_data   = '0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    case (state_q)
      ST_BUSY: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = base_q | ADDR_W'({beat_q, {WB_W{1'b0}}});
        mem_req_wr    = wr_q;
        if (wr_q && owner_q == OWN_DC) begin
          mem_wr_data = dc_wr_data;
        end
      end
      ST_DONE: begin
        ic_done = (owner_q == OWN_IC);
        dc_done = (owner_q == OWN_DC);
      end
      default: ;
    endcase
  end

  assign rdAccept = (state_q == ST_BUSY) && mem_req_ready && !wr_q;

  // Read data is registered, so the last response lands in the DONE cycle with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icRspValid_q <= 1'b0;
      dcRspValid_q <= 1'b0;
      rspData_q    <= '0;
    end else begin
      icRspValid_q <= rdAccept && (owner_q == OWN_IC);
      dcRspValid_q <= rdAccept && (owner_q == OWN_DC);
      if (rdAccept) begin
        rspData_q <= mem_req_data;
      end
    end
  end

  assign ic_rsp_valid = icRspValid_q;
  assign dc_rsp_valid = dcRspValid_q;
  assign ic_rsp_data  = icRspValid_q ? rspData_q : '0;
  assign dc_rsp_data  = dcRspValid_q ? rspData_q : '0;
  assign dc_beat_idx  = (owner_q == OWN_DC) ? beat_q : '0;

endmodule
